led_event_driver: RTL and testbench
===================================

LED_EVENT_DRIVER -- requirements
Module: led_event_driver

Interface
REQ-001 Parameter: ON_CYCLES, 25_000_000, LED high time per event in clock cycles (>=1).
REQ-002 Parameter: GAP_CYCLES, 12_500_000, forced LED low time after each pulse in clock cycles (>=1).
REQ-003 Parameter: MAX_PENDING, 7, maximum queued events (>=1).
REQ-004 Port: clock  input  1  50 MHz system clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: event_pulse  input  1  synchronous single-cycle event request (e.g. a synchronized button pressdown).
REQ-007 Port: enable  input  1  when 0, new events are ignored.
REQ-008 Port: overflow_clear  input  1  clears the sticky overflow flag.
REQ-009 Port: led  output  1  registered, glitch-free LED drive.
REQ-010 Port: busy  output  1  high while in ON or GAP.
REQ-011 Port: pending  output  $clog2(MAX_PENDING+1)  number of queued events not yet started.
REQ-012 Port: overflow  output  1  sticky; an event was dropped because the queue was full.

Function
REQ-013 FSM states: IDLE, ON, GAP; all outputs driven directly from registers.
REQ-014 event_pulse=1 and enable=1 at an edge: pending increments, unless pending=MAX_PENDING, in which case the event is dropped and overflow sets.
REQ-015 event_pulse with enable=0: ignored; no pending change, no overflow.
REQ-016 IDLE with pending>0 at an edge: go to ON, led<=1, pending decrements. An event sampled at edge k gives led=1 after edge k+1.
REQ-017 Increment and decrement at the same edge: pending unchanged; the full check uses the pre-edge value minus any same-edge decrement.
REQ-018 ON: led=1 for exactly ON_CYCLES cycles, then go to GAP with led<=0.
REQ-019 GAP: led=0 for exactly GAP_CYCLES cycles, then:
- go to ON (with dequeue) if pending>0;
- otherwise go to IDLE.
REQ-020 busy=1 exactly in ON and GAP; busy=0 in IDLE.
REQ-021 enable=0 does not abort a running pulse or gap, and does not flush pending; queued events still play out.
REQ-022 overflow_clear=1 clears overflow at the next edge; a simultaneous overflow set wins.
REQ-023 The timer is a down-counter of width $clog2(max(ON_CYCLES,GAP_CYCLES)) sized to fit both values; no wrap-around is permitted.

Reset
REQ-024 reset=1 immediately (without a clock edge) forces: state=IDLE, led=0, busy=0, pending=0, overflow=0, timer=0.
REQ-025 Reset asserted mid-ON or mid-GAP truncates the pulse immediately; queued events are discarded.
REQ-026 After reset deasserts, no pulse is produced without a new event.

Structure
REQ-027 Package led_event_pkg holds:
- typedef enum state_t {IDLE, ON, GAP};
- default constants CLOCK_FREQ_HZ=50_000_000, DEFAULT_ON_CYCLES, DEFAULT_GAP_CYCLES, DEFAULT_MAX_PENDING.
REQ-028 One sub-module, cycle_timer:
- load input with value;
- decrement every cycle;
- single-cycle expired output;
- async active-high reset.
REQ-029 The pending counter and FSM live in led_event_driver.

Verification (bench parameters ON_CYCLES=4, GAP_CYCLES=2, MAX_PENDING=3)
REQ-030 Single event at edge 10 -> led=1 after edge 11 through edge 15; busy=1 after edge 11, busy=0 after edge 17; pending 1 after edge 10, 0 after edge 11.
REQ-031 Events at edges 10, 11, 12 -> three pulses (4 cycles high / 2 cycles low) with no IDLE between them; pending never exceeds 2; busy falls 2 cycles after the third pulse ends.
REQ-032 One event, then 5 events during ON -> pending saturates at 3, overflow=1, exactly 4 pulses total; overflow_clear alone -> overflow=0 after the next edge.
REQ-033 overflow_clear=1 in the same cycle as a dropped event -> overflow remains 1.
REQ-034 reset=1 two cycles into ON with pending=2 -> led=0, pending=0, busy=0 before the next clock edge; after deassert, no pulse within 20 cycles.
REQ-035 enable=0 with an event mid-pulse -> pending unchanged, the current pulse completes normally, overflow stays 0.

Source files
------------

// File: rtl/led_event_pkg.sv
// Shared state encoding and default timing for the LED event driver.
package led_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  localparam int unsigned CLOCK_FREQ_HZ       = 50_000_000;
  localparam int unsigned DEFAULT_ON_CYCLES   = CLOCK_FREQ_HZ / 2;
  localparam int unsigned DEFAULT_GAP_CYCLES  = CLOCK_FREQ_HZ / 4;
  localparam int unsigned DEFAULT_MAX_PENDING = 7;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired pulses for one cycle when a loaded count runs out.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;
  logic             running;

  // The loaded value is the number of cycles minus one, so the full
  // duration fits in WIDTH bits and the counter never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= value;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - WIDTH'(1);
    end
  end

  assign expired = running && (count == '0);

endmodule

// File: rtl/led_event_driver.sv
// Queues single-cycle events and plays each one out as a fixed LED pulse followed by a forced gap.
module led_event_driver
  import led_event_pkg::*;
#(
  parameter int unsigned ON_CYCLES   = DEFAULT_ON_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int unsigned MAX_PENDING = DEFAULT_MAX_PENDING
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               event_pulse,
  input  logic                               enable,
  input  logic                               overflow_clear,
  output logic                               led,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int unsigned MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned PW         = $clog2(MAX_PENDING + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  state_t          state, state_d;
  logic            led_d, busy_d, overflow_d;
  logic [PW-1:0]   pending_d, pending_after;
  logic            timer_load, timer_expired, dequeue, accept;
  logic [TW-1:0]   timer_value;

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state;
    led_d       = led;
    busy_d      = busy;
    timer_load  = 1'b0;
    timer_value = '0;
    dequeue     = 1'b0;
    accept      = event_pulse && enable;

    case (state)
      IDLE: if (pending != '0) begin
        state_d = ON; led_d = 1'b1; busy_d = 1'b1; dequeue = 1'b1;
        timer_load = 1'b1; timer_value = ON_LOAD;
      end
      ON: if (timer_expired) begin
        state_d = GAP; led_d = 1'b0;
        timer_load = 1'b1; timer_value = GAP_LOAD;
      end
      GAP: if (timer_expired) begin
        if (pending != '0) begin
          state_d = ON; led_d = 1'b1; dequeue = 1'b1;
          timer_load = 1'b1; timer_value = ON_LOAD;
        end else begin
          state_d = IDLE; busy_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE; led_d = 1'b0; busy_d = 1'b0;
      end
    endcase

    // The full check sees the queue after any same-edge dequeue, so a
    // simultaneous start and new event leaves pending unchanged.
    pending_after = pending - PW'(dequeue);
    pending_d     = pending_after;
    overflow_d    = overflow && !overflow_clear;
    if (accept) begin
      if (pending_after == PW'(MAX_PENDING)) overflow_d = 1'b1;
      else                                   pending_d  = pending_after + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      led      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      led      <= led_d;
      busy     <= busy_d;
      pending  <= pending_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: tb/tb_led_event_driver.sv
// Directed and random stimulus checked against a timeline model of pulse slots and queue depth.
module tb_led_event_driver;

  localparam int ON  = 4;
  localparam int GAP = 2;
  localparam int MAX = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       event_pulse = 1'b0;
  logic       enable = 1'b0;
  logic       overflow_clear = 1'b0;
  logic       led, busy, overflow;
  logic [1:0] pending;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: edge index, start edge of the latest pulse, queue depth, sticky flag.
  int n = 0;
  int s = 0;
  bit started = 0;
  int q = 0;
  bit ov = 0;

  led_event_driver #(
    .ON_CYCLES   (ON),
    .GAP_CYCLES  (GAP),
    .MAX_PENDING (MAX)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .event_pulse    (event_pulse),
    .enable         (enable),
    .overflow_clear (overflow_clear),
    .led            (led),
    .busy           (busy),
    .pending        (pending),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all(input string tag);
    bit m_led, m_busy;
    m_led  = started && (n - s < ON);
    m_busy = started && (n - s < ON + GAP);
    chk({tag, ".led"}, {31'd0, led}, {31'd0, m_led});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
    chk({tag, ".pending"}, {30'd0, pending}, q);
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ov});
  endtask

  task automatic step(input logic ev, input logic en, input logic clr, input string tag);
    event_pulse = ev;
    enable = en;
    overflow_clear = clr;
    @(posedge clock);
    n++;
    if ((!started || n - s >= ON + GAP) && q > 0) begin
      started = 1;
      s = n;
      q--;
    end
    if (ev && en && q == MAX) ov = 1;
    else begin
      if (ev && en) q++;
      if (clr) ov = 0;
    end
    #1;
    event_pulse = 1'b0;
    enable = 1'b0;
    overflow_clear = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    #1;
    check_all("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    idle(9, "pre");
    step(1'b1, 1'b1, 1'b0, "single_ev");
    idle(10, "single");

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "b2b_ev");
    idle(22, "b2b");

    step(1'b1, 1'b1, 1'b0, "ovf_first");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, "ovf_burst");
    idle(30, "ovf_drain");
    step(1'b0, 1'b1, 1'b1, "ovf_clear");
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, "clr_fill");
    step(1'b1, 1'b1, 1'b1, "clr_vs_drop");
    chk("clr_vs_drop_sticky", {31'd0, overflow}, 32'd1);
    idle(30, "clr_drain");
    step(1'b0, 1'b0, 1'b1, "clr_final");

    step(1'b1, 1'b1, 1'b0, "dis_ev");
    idle(1, "dis_on");
    step(1'b1, 1'b0, 1'b0, "dis_mid");
    idle(8, "dis_finish");

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "rst_fill");
    idle(1, "rst_on");
    chk("rst_pre_pending", {30'd0, pending}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    started = 0;
    q = 0;
    ov = 0;
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b0;
    idle(20, "post_rst");

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
